// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life engine: mode encodings,
// button bit positions and the flat cell-index mapping.
package life_pkg;

    typedef enum logic [2:0] {
        ST_SET  = 3'b001,
        ST_RUN  = 3'b010,
        ST_STOP = 3'b100
    } state_e;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;
    localparam int BTN_S = 5;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// Purely combinational B3/S23 next-generation logic for a flat ROWS x COLS
// board; WRAP selects toroidal neighbours or dead off-board cells.
module life_next_gen
    import life_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int WRAP = 1
) (
    input  logic [ROWS*COLS-1:0] board,
    output logic [ROWS*COLS-1:0] next
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);

    function automatic logic [3:0] nbr_count(input logic [N-1:0] b, input int r, input int c);
        logic [3:0]    sum;
        logic [IW-1:0] ix;
        int            rr;
        int            cc;
        sum = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    rr = r + dr;
                    cc = c + dc;
                    if (WRAP != 0) begin
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
                        ix = IW'(cell_idx(rr, cc, COLS));
                        sum = sum + {3'b000, b[ix]};
                    end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                        ix = IW'(cell_idx(rr, cc, COLS));
                        sum = sum + {3'b000, b[ix]};
                    end
                end
            end
        end
        return sum;
    endfunction

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int IDX = cell_idx(r, c, COLS);
            logic [3:0] n;
            assign n         = nbr_count(board, r, c);
            assign next[IDX] = (n == 4'd3) | (board[IDX] & (n == 4'd2));
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game of Life controller: mode FSM, button edge detection, generation tick,
// row editing, generation counter and still-life / extinction flags.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int GEN_W    = 16,
    parameter int TICK_DIV = 33554432,
    parameter int WRAP     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_l,
    input  logic                    btn_r,
    input  logic                    btn_u,
    input  logic                    btn_d,
    input  logic                    btn_c,
    input  logic                    btn_s,
    input  logic [COLS-1:0]         row_data,
    output logic [ROWS*COLS-1:0]    board_o,
    output logic [GEN_W-1:0]        generation_cnt_o,
    output logic [2:0]              state_o,
    output logic [$clog2(ROWS)-1:0] cursor_o,
    output logic                    stable_o,
    output logic                    extinct_o
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(ROWS);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST_ROW  = CW'(ROWS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    board_q, board_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [CW-1:0]   cursor_q, cursor_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            stable_q, stable_d;
    logic            extinct_q, extinct_d;
    logic [5:0]      btn_prev_q, btn_prev_d;

    logic [5:0]      btn;
    logic [5:0]      rise;
    logic [N-1:0]    next_board;
    logic [IW-1:0]   row_base;
    logic            tick_hit;
    logic            do_gen;

    assign btn      = {btn_s, btn_c, btn_d, btn_u, btn_r, btn_l};
    assign rise     = btn & ~btn_prev_q;
    assign row_base = IW'(cell_idx(int'(cursor_q), 0, COLS));
    assign tick_hit = (state_q == ST_RUN) && (tick_q == TICK_LAST);

    life_next_gen #(
        .ROWS(ROWS),
        .COLS(COLS),
        .WRAP(WRAP)
    ) u_next_gen (
        .board(board_q),
        .next (next_board)
    );

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        gen_d      = gen_q;
        cursor_d   = cursor_q;
        tick_d     = tick_q;
        stable_d   = stable_q;
        btn_prev_d = btn;
        do_gen     = 1'b0;

        if (rise[BTN_L]) begin
            board_d  = '0;
            gen_d    = '0;
            cursor_d = '0;
            stable_d = 1'b0;
            tick_d   = '0;
            state_d  = ST_SET;
        end else if (rise[BTN_R]) begin
            // A mode change swallows any generation due on this same edge.
            tick_d = '0;
            case (state_q)
                ST_SET:  state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                default: state_d = ST_RUN;
            endcase
        end else begin
            if (state_q == ST_RUN) begin
                tick_d = tick_hit ? '0 : tick_q + TW'(1);
            end
            do_gen = tick_hit | ((state_q == ST_STOP) & rise[BTN_S]);
            if (do_gen) begin
                if (next_board != board_q) begin
                    board_d  = next_board;
                    gen_d    = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
                    stable_d = 1'b0;
                end else begin
                    stable_d = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_STOP;
                        tick_d  = '0;
                    end
                end
            end else if (state_q == ST_SET) begin
                if (rise[BTN_U] & ~rise[BTN_D]) begin
                    cursor_d = (cursor_q == '0) ? LAST_ROW : cursor_q - CW'(1);
                end else if (rise[BTN_D] & ~rise[BTN_U]) begin
                    cursor_d = (cursor_q == LAST_ROW) ? '0 : cursor_q + CW'(1);
                end
                // The write uses the cursor before any move on this edge.
                if (rise[BTN_C]) begin
                    board_d[row_base +: COLS] = row_data;
                    stable_d                  = 1'b0;
                end
            end
        end

        extinct_d = ~|board_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SET;
            board_q    <= '0;
            gen_q      <= '0;
            cursor_q   <= '0;
            tick_q     <= '0;
            stable_q   <= 1'b0;
            extinct_q  <= 1'b1;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            gen_q      <= gen_d;
            cursor_q   <= cursor_d;
            tick_q     <= tick_d;
            stable_q   <= stable_d;
            extinct_q  <= extinct_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign board_o          = board_q;
    assign generation_cnt_o = gen_q;
    assign state_o          = state_q;
    assign cursor_o         = cursor_q;
    assign stable_o         = stable_q;
    assign extinct_o        = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine on an 8x8 board with TICK_DIV=4; a
// toroidal instance and a dead-edge instance share the same stimulus.
module tb_life_engine;

    localparam logic [5:0] L = 6'b000001;
    localparam logic [5:0] R = 6'b000010;
    localparam logic [5:0] U = 6'b000100;
    localparam logic [5:0] D = 6'b001000;
    localparam logic [5:0] C = 6'b010000;
    localparam logic [5:0] S = 6'b100000;

    localparam int SEL_BOARD = 0, SEL_GEN = 1, SEL_STATE = 2, SEL_CUR = 3;
    localparam int SEL_STB = 4, SEL_EXT = 5;
    localparam int SEL_BOARD0 = 6, SEL_GEN0 = 7, SEL_STATE0 = 8, SEL_STB0 = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_l = 0, btn_r = 0, btn_u = 0, btn_d = 0, btn_c = 0, btn_s = 0;
    logic [7:0]  row_data = '0;

    logic [63:0] board, board0;
    logic [15:0] gen, gen0;
    logic [2:0]  st, st0, cur, cur0;
    logic        stb, stb0, ext, ext0;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [63:0] act;
    logic        chk_vld = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          tcur = 0;

    always #5 clk = ~clk;

    life_engine #(.ROWS(8), .COLS(8), .GEN_W(16), .TICK_DIV(4), .WRAP(1)) dut (
        .clk(clk), .reset(reset),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c), .btn_s(btn_s),
        .row_data(row_data),
        .board_o(board), .generation_cnt_o(gen), .state_o(st), .cursor_o(cur),
        .stable_o(stb), .extinct_o(ext)
    );

    life_engine #(.ROWS(8), .COLS(8), .GEN_W(16), .TICK_DIV(4), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset),
        .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c), .btn_s(btn_s),
        .row_data(row_data),
        .board_o(board0), .generation_cnt_o(gen0), .state_o(st0), .cursor_o(cur0),
        .stable_o(stb0), .extinct_o(ext0)
    );

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            SEL_BOARD:  return board;
            SEL_GEN:    return 64'(gen);
            SEL_STATE:  return 64'(st);
            SEL_CUR:    return 64'(cur);
            SEL_STB:    return 64'(stb);
            SEL_EXT:    return 64'(ext);
            SEL_BOARD0: return board0;
            SEL_GEN0:   return 64'(gen0);
            SEL_STATE0: return 64'(st0);
            default:    return 64'(stb0);
        endcase
    endfunction

    // Monitor: whenever a check window is presented, drain and compare.
    always @(posedge clk) begin
        #1;
        if (chk_vld) begin
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = actual(e.sel);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic press(input logic [5:0] m);
        {btn_s, btn_c, btn_d, btn_u, btn_r, btn_l} = m;
        @(negedge clk);
        {btn_s, btn_c, btn_d, btn_u, btn_r, btn_l} = 6'b0;
        @(negedge clk);
    endtask

    task automatic expect_v(input string nm, input int sel, input logic [63:0] v);
        sb_q.push_back('{nm, sel, v});
    endtask

    task automatic commit();
        chk_vld = 1'b1;
        @(negedge clk);
        chk_vld = 1'b0;
    endtask

    task automatic clear_board();
        press(L);
        tcur = 0;
    endtask

    task automatic write_row(input int r, input logic [7:0] d);
        while (tcur != r) begin
            press(D);
            tcur = (tcur + 1) % 8;
        end
        row_data = d;
        press(C);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_v("rst_board", SEL_BOARD, 64'h0);
        expect_v("rst_gen", SEL_GEN, 64'd0);
        expect_v("rst_state", SEL_STATE, 64'b001);
        expect_v("rst_cursor", SEL_CUR, 64'd0);
        expect_v("rst_extinct", SEL_EXT, 64'd1);
        expect_v("rst_stable", SEL_STB, 64'd0);
        commit();

        // Blinker, single steps
        write_row(3, 8'b00011100);
        expect_v("blk_write", SEL_BOARD, 64'h0000_0000_1C00_0000);
        expect_v("blk_cursor", SEL_CUR, 64'd3);
        expect_v("blk_ext0", SEL_EXT, 64'd0);
        commit();
        press(R);
        press(R);
        expect_v("blk_stop", SEL_STATE, 64'b100);
        expect_v("blk_gen0", SEL_GEN, 64'd0);
        commit();
        press(S);
        expect_v("blk_step1", SEL_BOARD, 64'h0000_0008_0808_0000);
        expect_v("blk_gen1", SEL_GEN, 64'd1);
        expect_v("blk_step1_nowrap", SEL_BOARD0, 64'h0000_0008_0808_0000);
        commit();
        press(S);
        expect_v("blk_step2", SEL_BOARD, 64'h0000_0000_1C00_0000);
        expect_v("blk_gen2", SEL_GEN, 64'd2);
        expect_v("blk_stb2", SEL_STB, 64'd0);
        commit();

        // Block in RUN: still life detected on the first tick
        clear_board();
        write_row(2, 8'b00011000);
        write_row(3, 8'b00011000);
        press(R);
        expect_v("blockrun_state_t2", SEL_STATE, 64'b010);
        expect_v("blockrun_stb_t2", SEL_STB, 64'd0);
        commit();
        expect_v("blockrun_state_t3", SEL_STATE, 64'b010);
        commit();
        expect_v("blockrun_stable", SEL_STB, 64'd1);
        expect_v("blockrun_state", SEL_STATE, 64'b100);
        expect_v("blockrun_gen", SEL_GEN, 64'd0);
        expect_v("blockrun_board", SEL_BOARD, 64'h0000_0000_1818_0000);
        commit();

        // Single cell dies, then the empty board is stable
        clear_board();
        write_row(0, 8'b00000100);
        press(R);
        press(R);
        press(S);
        expect_v("single_board", SEL_BOARD, 64'h0);
        expect_v("single_ext", SEL_EXT, 64'd1);
        expect_v("single_gen", SEL_GEN, 64'd1);
        expect_v("single_stb0", SEL_STB, 64'd0);
        commit();
        press(S);
        expect_v("single_stable", SEL_STB, 64'd1);
        expect_v("single_gen_hold", SEL_GEN, 64'd1);
        expect_v("single_state", SEL_STATE, 64'b100);
        commit();

        // Glider: 32 ticks around the torus; dead edges turn it into a block
        clear_board();
        write_row(0, 8'b00000010);
        write_row(1, 8'b00000100);
        write_row(2, 8'b00000111);
        press(R);
        repeat (127) @(negedge clk);
        expect_v("glider_gen", SEL_GEN, 64'd32);
        expect_v("glider_board", SEL_BOARD, 64'h0000_0000_0007_0402);
        expect_v("glider_state", SEL_STATE, 64'b010);
        expect_v("glider0_board", SEL_BOARD0, 64'hC0C0_0000_0000_0000);
        expect_v("glider0_gen", SEL_GEN0, 64'd23);
        expect_v("glider0_state", SEL_STATE0, 64'b100);
        expect_v("glider0_stable", SEL_STB0, 64'd1);
        commit();

        // Cursor edge cases
        clear_board();
        press(U);
        expect_v("cursor_wrap_up", SEL_CUR, 64'd7);
        commit();
        press(U | D);
        expect_v("cursor_ud_same", SEL_CUR, 64'd7);
        commit();

        // Clear in the middle of RUN
        clear_board();
        write_row(3, 8'b00011100);
        press(R);
        repeat (19) @(negedge clk);
        expect_v("midrun_gen5", SEL_GEN, 64'd5);
        expect_v("midrun_state", SEL_STATE, 64'b010);
        commit();
        press(L);
        tcur = 0;
        expect_v("clr_board", SEL_BOARD, 64'h0);
        expect_v("clr_gen", SEL_GEN, 64'd0);
        expect_v("clr_state", SEL_STATE, 64'b001);
        expect_v("clr_cursor", SEL_CUR, 64'd0);
        expect_v("clr_ext", SEL_EXT, 64'd1);
        commit();

        // Held btn_r: exactly one mode transition
        write_row(3, 8'b00011100);
        btn_r = 1'b1;
        repeat (10) @(negedge clk);
        btn_r = 1'b0;
        expect_v("held_r_state", SEL_STATE, 64'b010);
        expect_v("held_r_gen", SEL_GEN, 64'd2);
        expect_v("held_r_board", SEL_BOARD, 64'h0000_0000_1C00_0000);
        commit();

        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
